// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) to one-slave pipelined Wishbone arbiter, ownership held per cyc.
// Define MEM_ARBITER_ROUND_ROBIN_EN to alternate winners on simultaneous requests instead of using LS_PRIORITY.
module mem_arbiter #(
  parameter bit LS_PRIORITY = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_wb_adr_i,
  input  logic [31:0] if_wb_dat_i,
  input  logic        if_wb_we_i,
  input  logic [3:0]  if_wb_sel_i,
  input  logic        if_wb_stb_i,
  input  logic        if_wb_cyc_i,
  output logic [31:0] if_wb_dat_o,
  output logic        if_wb_ack_o,
  output logic        if_wb_stall_o,
  input  logic [31:0] ls_wb_adr_i,
  input  logic [31:0] ls_wb_dat_i,
  input  logic        ls_wb_we_i,
  input  logic [3:0]  ls_wb_sel_i,
  input  logic        ls_wb_stb_i,
  input  logic        ls_wb_cyc_i,
  output logic [31:0] ls_wb_dat_o,
  output logic        ls_wb_ack_o,
  output logic        ls_wb_stall_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
);

  localparam int NM   = 2;
  localparam int M_IF = 0;
  localparam int M_LS = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_LS = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Master-side buses gathered into arrays so the per-master muxing is one generate loop.
  logic [31:0]   m_adr [NM];
  logic [31:0]   m_dat [NM];
  logic [3:0]    m_sel [NM];
  logic [NM-1:0] m_we;
  logic [NM-1:0] m_stb;
  logic [NM-1:0] m_cyc;
  logic [NM-1:0] m_ack;
  logic [NM-1:0] m_stall;
  logic [NM-1:0] grant;

  assign m_adr[M_IF] = if_wb_adr_i;
  assign m_adr[M_LS] = ls_wb_adr_i;
  assign m_dat[M_IF] = if_wb_dat_i;
  assign m_dat[M_LS] = ls_wb_dat_i;
  assign m_sel[M_IF] = if_wb_sel_i;
  assign m_sel[M_LS] = ls_wb_sel_i;
  assign m_we        = {ls_wb_we_i,  if_wb_we_i};
  assign m_stb       = {ls_wb_stb_i, if_wb_stb_i};
  assign m_cyc       = {ls_wb_cyc_i, if_wb_cyc_i};

  assign grant[M_IF] = (state_q == GRANT_IF);
  assign grant[M_LS] = (state_q == GRANT_LS);

  logic ls_wins;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;  // 1 = load/store owned the bus last

  assign ls_wins = ~last_owner_q;

  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_q == IDLE) && (state_d != IDLE)) begin
      last_owner_d = (state_d == GRANT_LS);
    end
  end
`else
  assign ls_wins = LS_PRIORITY;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (if_wb_cyc_i && ls_wb_cyc_i) begin
          state_d = ls_wins ? GRANT_LS : GRANT_IF;
        end else if (if_wb_cyc_i) begin
          state_d = GRANT_IF;
        end else if (ls_wb_cyc_i) begin
          state_d = GRANT_LS;
        end
      end
      GRANT_IF: if (!if_wb_cyc_i) state_d = IDLE;
      GRANT_LS: if (!ls_wb_cyc_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  logic [31:0]   adr_term [NM];
  logic [31:0]   dat_term [NM];
  logic [3:0]    sel_term [NM];
  logic [NM-1:0] we_term;
  logic [NM-1:0] stb_term;
  logic [NM-1:0] cyc_term;

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_master
      assign adr_term[gi] = grant[gi] ? m_adr[gi] : 32'd0;
      assign dat_term[gi] = grant[gi] ? m_dat[gi] : 32'd0;
      assign sel_term[gi] = grant[gi] ? m_sel[gi] : 4'd0;
      assign we_term[gi]  = grant[gi] & m_we[gi];
      // stb is qualified by cyc so the releasing cycle never leaks a strobe.
      assign cyc_term[gi] = grant[gi] & m_cyc[gi];
      assign stb_term[gi] = grant[gi] & m_cyc[gi] & m_stb[gi];
      assign m_ack[gi]    = grant[gi] & wb_ack_i;
      assign m_stall[gi]  = ~grant[gi] | wb_stall_i;
    end
  endgenerate

  assign wb_adr_o = adr_term[M_IF] | adr_term[M_LS];
  assign wb_dat_o = dat_term[M_IF] | dat_term[M_LS];
  assign wb_sel_o = sel_term[M_IF] | sel_term[M_LS];
  assign wb_we_o  = |we_term;
  assign wb_stb_o = |stb_term;
  assign wb_cyc_o = |cyc_term;

  assign if_wb_ack_o   = m_ack[M_IF];
  assign ls_wb_ack_o   = m_ack[M_LS];
  assign if_wb_stall_o = m_stall[M_IF];
  assign ls_wb_stall_o = m_stall[M_LS];

  // Read data is broadcast; each master qualifies it with its own ack.
  assign if_wb_dat_o = wb_dat_i;
  assign ls_wb_dat_o = wb_dat_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic against an ownership model.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] if_adr, if_dat, ls_adr, ls_dat;
  logic        if_we, if_stb, if_cyc, ls_we, ls_stb, ls_cyc;
  logic [3:0]  if_sel, ls_sel;
  logic [31:0] if_dat_o, ls_dat_o;
  logic        if_ack_o, if_stall_o, ls_ack_o, ls_stall_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_stall_i;
  logic [3:0]  wb_sel_o;

  localparam bit LSP = 1'b1;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.LS_PRIORITY(LSP)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_wb_adr_i(if_adr), .if_wb_dat_i(if_dat), .if_wb_we_i(if_we), .if_wb_sel_i(if_sel),
    .if_wb_stb_i(if_stb), .if_wb_cyc_i(if_cyc), .if_wb_dat_o(if_dat_o), .if_wb_ack_o(if_ack_o),
    .if_wb_stall_o(if_stall_o),
    .ls_wb_adr_i(ls_adr), .ls_wb_dat_i(ls_dat), .ls_wb_we_i(ls_we), .ls_wb_sel_i(ls_sel),
    .ls_wb_stb_i(ls_stb), .ls_wb_cyc_i(ls_cyc), .ls_wb_dat_o(ls_dat_o), .ls_wb_ack_o(ls_ack_o),
    .ls_wb_stall_o(ls_stall_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i)
  );

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int txn_n  = 0;
  int owner  = 0;  // 0 = nobody, 1 = fetch, 2 = load/store
  int rr_last = 1; // last owner for alternating arbitration (1 = fetch)

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc_n, got, exp);
    end
  endtask

  function automatic int pick_winner();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    return (rr_last == 1) ? 2 : 1;
`else
    return LSP ? 2 : 1;
`endif
  endfunction

  // Inputs are set just after a falling edge; outputs checked 1ns later; model advances across the rising edge.
  task automatic cycle();
    logic [127:0] exp_slv, exp_if, exp_ls;
    int nxt;
    #1;
    exp_slv = '0;
    if (owner == 1) exp_slv = {if_adr, if_dat, if_we, if_sel, if_stb & if_cyc, if_cyc};
    if (owner == 2) exp_slv = {ls_adr, ls_dat, ls_we, ls_sel, ls_stb & ls_cyc, ls_cyc};
    exp_if = {wb_dat_i, (owner == 1) ? wb_ack_i : 1'b0, (owner == 1) ? wb_stall_i : 1'b1};
    exp_ls = {wb_dat_i, (owner == 2) ? wb_ack_i : 1'b0, (owner == 2) ? wb_stall_i : 1'b1};
    chk("slave_bus", {wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o}, exp_slv);
    chk("if_side", {if_dat_o, if_ack_o, if_stall_o}, exp_if);
    chk("ls_side", {ls_dat_o, ls_ack_o, ls_stall_o}, exp_ls);

    if (rst_i) begin
      nxt = 0;
    end else if (owner == 0) begin
      if (if_cyc && ls_cyc) nxt = pick_winner();
      else if (if_cyc)      nxt = 1;
      else if (ls_cyc)      nxt = 2;
      else                  nxt = 0;
    end else if (owner == 1) begin
      nxt = if_cyc ? 1 : 0;
    end else begin
      nxt = ls_cyc ? 2 : 0;
    end

    if (rst_i) rr_last = 1;
    else if (owner == 0 && nxt != 0) begin
      rr_last = nxt;
      txn_n++;
      $display("txn %0d: grant to %s at cycle %0d", txn_n, (nxt == 1) ? "if" : "ls", cyc_n + 1);
    end
    owner = nxt;
    cyc_n++;
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    if_adr = '0; if_dat = '0; if_we = 0; if_sel = '0; if_stb = 0; if_cyc = 0;
    ls_adr = '0; ls_dat = '0; ls_we = 0; ls_sel = '0; ls_stb = 0; ls_cyc = 0;
    wb_dat_i = '0; wb_ack_i = 0; wb_stall_i = 0;
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    @(negedge clk_i);
    owner = 0;
    cycle();
    cycle();
    rst_i = 1'b0;
    cycle();

    // Single fetch, ack two cycles after the grant.
    if_cyc = 1; if_stb = 1; if_adr = 32'h100; if_sel = 4'hF;
    cycle();
    cycle();
    if_stb = 0; cycle();
    wb_ack_i = 1; wb_dat_i = 32'h1234_5678; cycle();
    wb_ack_i = 0; if_cyc = 0; cycle();
    cycle();

    // Contention: ls wins, then slave stalls it for 3 cycles.
    if_cyc = 1; if_stb = 1; if_adr = 32'h200;
    ls_cyc = 1; ls_stb = 1; ls_adr = 32'h8000; ls_we = 1; ls_sel = 4'hF; ls_dat = 32'hDEAD_BEEF;
    cycle();
    wb_stall_i = 1; cycle(); cycle(); cycle();
    wb_stall_i = 0; cycle();
    ls_stb = 0; wb_ack_i = 1; cycle();
    wb_ack_i = 0; ls_cyc = 0; ls_we = 0; cycle();
    cycle();
    if_stb = 0; wb_ack_i = 1; cycle();
    wb_ack_i = 0; if_cyc = 0; cycle();

    // Reset mid-transfer with an ack still pending.
    ls_cyc = 1; ls_stb = 1; ls_adr = 32'h40; cycle();
    ls_stb = 0; cycle();
    rst_i = 1; cycle();
    rst_i = 0; ls_cyc = 0; wb_ack_i = 1; cycle();
    wb_ack_i = 0; cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (if_cyc) begin
        if ($urandom_range(5) == 0) if_cyc = 0;
      end else if ($urandom_range(3) == 0) if_cyc = 1;
      if (ls_cyc) begin
        if ($urandom_range(5) == 0) ls_cyc = 0;
      end else if ($urandom_range(3) == 0) ls_cyc = 1;
      if_stb = if_cyc ? $urandom_range(1) : ($urandom_range(7) == 0);
      ls_stb = ls_cyc ? $urandom_range(1) : ($urandom_range(7) == 0);
      if_adr = $urandom; if_dat = $urandom; if_we = $urandom_range(1); if_sel = 4'($urandom);
      ls_adr = $urandom; ls_dat = $urandom; ls_we = $urandom_range(1); ls_sel = 4'($urandom);
      wb_dat_i   = $urandom;
      wb_ack_i   = ($urandom_range(2) == 0);
      wb_stall_i = ($urandom_range(2) == 0);
      rst_i      = ($urandom_range(99) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
